serial_subtractor5: RTL and testbench

Bit-serial two's-complement subtractor for the Lab4 datapath. It computes A − B − borrow_in one bit per clock, LSB first. It reuses a single fullAdder instance and a borrow/carry flip-flop. It is the sequential, subtracting counterpart of the 5-bit ripple adder, and uses a start/busy/done handshake.

---
 rtl/lab4_pkg.sv | 17 +
 rtl/serial_subtractor5_if.sv | 26 ++
 rtl/fullAdder.sv | 14 +
 rtl/serial_subtractor5.sv | 92 +++++++++
 tb/tb_serial_subtractor5.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lab4_pkg.sv
// Shared Lab4 datapath definitions.
// FSM state encoding and default operand width.
package lab4_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor5_if.sv
// start/busy/done bus for the serial subtractor.
// master drives request+operands, slave returns status+result.
interface serial_subtractor5_if #(
  parameter int WIDTH = lab4_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_d;
  logic             out_b;

  modport master (
    output start, in_a, in_b, in_c,
    input  busy, done, out_d, out_b
  );

  modport slave (
    input  start, in_a, in_b, in_c,
    output busy, done, out_d, out_b
  );

endinterface

// File: rtl/fullAdder.sv
// One-bit full adder from lab4_1.
// Ports: a, b, cin in; sum, cout out.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor5.sv
// Bit-serial A - B - borrow_in, LSB first, one fullAdder.
// Ports: clk, reset (sync, high), bus (slave: start/operands in, busy/done/out_d/out_b out).
module serial_subtractor5
  import lab4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_subtractor5_if.slave  bus
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry_ff;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             b_q;
  logic             sum;
  logic             cout;
  logic [WIDTH-1:0] res_nxt;

  // Subtraction as a + ~b + ~bin: carry set means no borrow.
  fullAdder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_ff),
    .sum  (sum),
    .cout (cout)
  );

  assign res_nxt = {sum, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry_ff <= 1'b0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      b_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.in_a;
            b_sh     <= ~bus.in_b;
            carry_ff <= ~bus.in_c;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res      <= res_nxt;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          carry_ff <= cout;
          count    <= count + 1'b1;
          if (count == LAST) begin
            d_q    <= res_nxt;
            b_q    <= ~cout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out_d = d_q;
  assign bus.out_b = b_q;

endmodule

// File: tb/tb_serial_subtractor5.sv
// Bench for serial_subtractor5: directed cases plus random ops
// against an integer model of a - b - c.
module tb_serial_subtractor5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] prev_d;
  logic       prev_b;

  serial_subtractor5_if #(.WIDTH(5)) bus ();

  serial_subtractor5 #(.WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // {borrow, diff} from plain integer arithmetic
  function automatic logic [5:0] model(int a, int b, int c);
    int diff;
    logic [5:0] r;
    diff = a - b - c;
    r[4:0] = 5'(diff & 31);
    r[5]   = (diff < 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive request for one edge; caller sits #1 after an edge.
  task automatic accept(int a, int b, int c, bit hold);
    bus.start = 1'b1;
    bus.in_a  = 5'(a);
    bus.in_b  = 5'(b);
    bus.in_c  = 1'(c);
    tick();
    bus.start = hold;
    if (!hold) begin
      bus.in_a = 5'($urandom);
      bus.in_b = 5'($urandom);
      bus.in_c = 1'($urandom);
    end
  endtask

  // Walk busy cycles 1..5, end in the done cycle.
  task automatic run_shift(int a, int b, int c, int ign_cyc);
    logic [5:0] e;
    e = model(a, b, c);
    for (int k = 1; k <= 5; k++) begin
      check_eq("busy", 32'(bus.busy), 1);
      check_eq("done_early", 32'(bus.done), 0);
      check_eq("hold_d", 32'(bus.out_d), 32'(prev_d));
      check_eq("hold_b", 32'(bus.out_b), 32'(prev_b));
      if (k == ign_cyc) begin
        bus.start = 1'b1;
        bus.in_a  = 5'd1;
        bus.in_b  = 5'd2;
        bus.in_c  = 1'b0;
      end
      tick();
      if (k == ign_cyc) bus.start = 1'b0;
    end
    check_eq("done", 32'(bus.done), 1);
    check_eq("busy_done", 32'(bus.busy), 0);
    check_eq("out_d", 32'(bus.out_d), 32'(e[4:0]));
    check_eq("out_b", 32'(bus.out_b), 32'(e[5]));
    prev_d = e[4:0];
    prev_b = e[5];
  endtask

  task automatic idle_check(int n);
    for (int g = 0; g < n; g++) begin
      tick();
      check_eq("idle_done", 32'(bus.done), 0);
      check_eq("idle_busy", 32'(bus.busy), 0);
      check_eq("idle_d", 32'(bus.out_d), 32'(prev_d));
      check_eq("idle_b", 32'(bus.out_b), 32'(prev_b));
    end
  endtask

  initial begin
    int a, b, c, gap;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_c  = 1'b0;
    prev_d    = '0;
    prev_b    = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_d", 32'(bus.out_d), 0);
    check_eq("rst_b", 32'(bus.out_b), 0);
    reset = 1'b0;
    tick();

    accept(13, 6, 0, 0);
    run_shift(13, 6, 0, 0);
    idle_check(2);
    accept(6, 13, 0, 0);
    run_shift(6, 13, 0, 0);
    idle_check(1);
    accept(0, 0, 1, 0);
    run_shift(0, 0, 1, 0);
    idle_check(1);
    accept(31, 31, 0, 0);
    run_shift(31, 31, 0, 0);
    idle_check(1);

    // request during SHIFT must be dropped
    accept(20, 4, 0, 0);
    run_shift(20, 4, 0, 2);
    idle_check(4);

    // reset on the third shift edge
    accept(9, 3, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_done", 32'(bus.done), 0);
    check_eq("abort_d", 32'(bus.out_d), 0);
    check_eq("abort_b", 32'(bus.out_b), 0);
    prev_d = '0;
    prev_b = 1'b0;
    idle_check(8);
    accept(9, 3, 0, 0);
    run_shift(9, 3, 0, 0);
    idle_check(1);

    // back-to-back with start held high
    accept(10, 5, 0, 1);
    run_shift(10, 5, 0, 0);
    accept(5, 10, 0, 0);
    run_shift(5, 10, 0, 0);
    idle_check(2);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      c = int'($urandom_range(0, 1));
      accept(a, b, c, 0);
      run_shift(a, b, c, 0);
      gap = int'($urandom_range(0, 2));
      idle_check(gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
